// File: rtl/buffer_shift_pkg.sv
// Shared definitions for the buffer shift register and its sequencer:
// shift-register mode codes and the sequencer FSM state encoding.
package buffer_shift_pkg;

  localparam logic [3:0] PAD_INIT_1   = 4'd0;
  localparam logic [3:0] PAD_INIT_2   = 4'd1;
  localparam logic [3:0] PAD_UINIT_1  = 4'd2;
  localparam logic [3:0] PAD_UINIT_2  = 4'd3;
  localparam logic [3:0] UPAD_INIT_1  = 4'd4;
  localparam logic [3:0] UPAD_INIT_2  = 4'd5;
  localparam logic [3:0] UPAD_UINIT_1 = 4'd6;
  localparam logic [3:0] UPAD_UINIT_2 = 4'd7;
  localparam logic [3:0] PAD_END_3    = 4'd8;
  localparam logic [3:0] PAD_END_4    = 4'd9;
  localparam logic [3:0] IDLE_CODE    = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_STREAM,
    ST_END3,
    ST_END4
  } seq_state_t;

endpackage

// File: rtl/buffer_shift_sequencer.sv
// Command-driven sequencer producing per-cycle mode codes, mux selects and zero
// masks for the buffer shift register. BUFSHIFT_SEQ_BACK2BACK_EN allows a new
// command to be accepted on the line_done cycle.
module buffer_shift_sequencer
  import buffer_shift_pkg::*;
#(
  parameter int X_MAC      = 4,
  parameter int MUXCONTROL = 4,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_pad,
  input  logic                  cmd_align,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [2*X_MAC-1:0]    cmd_buffermux,
  input  logic [X_MAC-1:0]      cmd_iszero,
  output logic [MUXCONTROL-1:0] control,
  output logic [2*X_MAC-1:0]    buffermux,
  output logic [X_MAC-1:0]      iszero,
  output logic                  word_req,
  output logic                  busy,
  output logic                  line_done
);

  seq_state_t            state, state_n;
  logic [LEN_W-1:0]      cnt, cnt_n;
  logic                  phase, phase_n;
  logic                  pad_q, pad_n;
  logic [2*X_MAC-1:0]    buffermux_n;
  logic [X_MAC-1:0]      iszero_n;
  logic [MUXCONTROL-1:0] control_n;
  logic                  word_req_n, line_done_n;
  logic [3:0]            code;
  logic                  accept;

`ifdef BUFSHIFT_SEQ_BACK2BACK_EN
  assign cmd_ready = (state == ST_IDLE) || line_done;
`else
  assign cmd_ready = (state == ST_IDLE);
`endif
  assign accept = cmd_valid && cmd_ready;
  assign busy   = (state != ST_IDLE);

  // Next state is computed first; the registered outputs are then derived
  // from that next state so they line up with the cycle they describe.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_n     = state;
    cnt_n       = cnt;
    phase_n     = phase;
    pad_n       = pad_q;
    buffermux_n = buffermux;
    iszero_n    = iszero;
    control_n   = MUXCONTROL'(IDLE_CODE);
    word_req_n  = 1'b0;
    line_done_n = 1'b0;
    code        = IDLE_CODE;

    if (accept) begin
      state_n     = ST_INIT;
      cnt_n       = cmd_len;
      phase_n     = cmd_align;
      pad_n       = cmd_pad;
      buffermux_n = cmd_buffermux;
      iszero_n    = cmd_iszero;
    end else begin
      unique case (state)
        ST_INIT:   state_n = (cnt != '0) ? ST_STREAM : (pad_q ? ST_END3 : ST_IDLE);
        ST_STREAM: begin
          if (cnt == LEN_W'(1)) begin
            state_n = pad_q ? ST_END3 : ST_IDLE;
          end else begin
            cnt_n   = cnt - LEN_W'(1);
            phase_n = ~phase;
          end
        end
        ST_END3:   state_n = ST_END4;
        ST_END4:   state_n = ST_IDLE;
        default:   state_n = ST_IDLE;
      endcase
    end

    unique case (state_n)
      ST_INIT: begin
        code        = (pad_n ? PAD_INIT_1 : UPAD_INIT_1) + {3'b000, phase_n};
        word_req_n  = 1'b1;
        line_done_n = (cnt_n == '0) && !pad_n;
      end
      ST_STREAM: begin
        code        = (pad_n ? PAD_UINIT_1 : UPAD_UINIT_1) + {3'b000, phase_n};
        word_req_n  = !phase_n;
        line_done_n = (cnt_n == LEN_W'(1)) && !pad_n;
      end
      ST_END3: code = PAD_END_3;
      ST_END4: begin
        code        = PAD_END_4;
        line_done_n = 1'b1;
      end
      default: begin
        code        = IDLE_CODE;
        buffermux_n = '0;
        iszero_n    = '0;
      end
    endcase
    control_n = MUXCONTROL'(code);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state     <= ST_IDLE;
      cnt       <= '0;
      phase     <= 1'b0;
      pad_q     <= 1'b0;
      control   <= MUXCONTROL'(IDLE_CODE);
      buffermux <= '0;
      iszero    <= '0;
      word_req  <= 1'b0;
      line_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      phase     <= phase_n;
      pad_q     <= pad_n;
      control   <= control_n;
      buffermux <= buffermux_n;
      iszero    <= iszero_n;
      word_req  <= word_req_n;
      line_done <= line_done_n;
    end
  end

endmodule
